imem_arbiter: RTL

- Controller that shares the single-port instruction memory between two requesters:
  - the IF-stage fetch port (read-only);
  - the program-loader/debug port (read or write).
- Sequences each access through a small FSM and enforces word alignment and range checks.
- Applies loader-priority arbitration with a fetch anti-starvation counter.
- Sits between the fetch stage/loader and the imem array; the fetch stage stalls while if_gnt is low.

---
 rtl/imem_arbiter_if.sv | 44 ++++
 rtl/imem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Requester and memory-side bus bundle for imem_arbiter.
// slave = arbiter side; master = requesters plus the imem array.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024
);
    localparam int unsigned MAW = $clog2(DEPTH_WORDS);

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;
    logic                  if_err;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [31:0]           ld_wdata;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [31:0]           ld_rdata;
    logic                  ld_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [MAW-1:0]        mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ld_gnt, ld_rvalid, ld_rdata, ld_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port imem between the fetch port and the loader/debug port.
// Optional loader write protection of the low region: define IMEM_WRITE_PROTECT_EN.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned MEM_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned PROTECT_WORDS = 64,
    parameter logic [31:0] NOP_WORD      = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
);
    localparam int unsigned MAW = $clog2(DEPTH_WORDS);
    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           owner_ld_q, owner_ld_d;
    logic           we_q, we_d;
    logic           legal_q, legal_d;
    logic [MAW-1:0] addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [LW-1:0]  wcnt_q, wcnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic  starved;
    logic  pick_ld;
    logic  pick_if;
    addr_t sel_addr;
    addr_t sel_word;
    logic  sel_we;
    logic  sel_aligned;
    logic  sel_in_range;
    logic  wp_hit;
    logic  sel_legal;

    // Loader has priority unless fetch has already lost STARVE_LIMIT times in a row.
    always_comb begin
        starved      = (starve_q == SW'(STARVE_LIMIT));
        pick_ld      = bus.ld_req && !(bus.if_req && starved);
        pick_if      = bus.if_req && !pick_ld;
        sel_addr     = pick_ld ? bus.ld_addr : bus.if_addr;
        sel_word     = {2'b00, sel_addr[ADDR_WIDTH-1:2]};
        sel_we       = pick_ld && bus.ld_we;
        sel_aligned  = (sel_addr[1:0] == 2'b00);
        sel_in_range = (sel_word < addr_t'(DEPTH_WORDS));
`ifdef IMEM_WRITE_PROTECT_EN
        wp_hit       = sel_we && (sel_word < addr_t'(PROTECT_WORDS));
`else
        wp_hit       = 1'b0;
`endif
        sel_legal    = sel_aligned && sel_in_range && !wp_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_ld_q <= 1'b0;
            we_q       <= 1'b0;
            legal_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wcnt_q     <= '0;
            starve_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_ld_q <= owner_ld_d;
            we_q       <= we_d;
            legal_q    <= legal_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wcnt_q     <= wcnt_d;
            starve_q   <= starve_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_ld_d = owner_ld_q;
        we_d       = we_q;
        legal_d    = legal_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wcnt_d     = wcnt_q;
        starve_d   = starve_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_ld || pick_if) begin
                    state_d    = S_ISSUE;
                    owner_ld_d = pick_ld;
                    we_d       = sel_we;
                    legal_d    = sel_legal;
                    addr_d     = sel_addr[MAW+1:2];
                    wdata_d    = pick_ld ? bus.ld_wdata : '0;
                    // Writes and illegal accesses know their response now; legal reads overwrite it later.
                    err_d      = !sel_legal;
                    rdata_d    = (!sel_legal && !sel_we) ? NOP_WORD : '0;
                    if (pick_if) begin
                        starve_d = '0;
                    end else if (bus.if_req && !starved) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (!legal_q) begin
                    state_d = S_RESP;
                end else if (MEM_LATENCY == 0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = LW'(MEM_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q - LW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.if_err    = 1'b0;
        bus.ld_gnt    = 1'b0;
        bus.ld_rvalid = 1'b0;
        bus.ld_rdata  = '0;
        bus.ld_err    = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            S_ISSUE: begin
                bus.if_gnt = !owner_ld_q;
                bus.ld_gnt = owner_ld_q;
                if (legal_q) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = we_q;
                    bus.mem_addr  = addr_q;
                    bus.mem_wdata = wdata_q;
                end
            end
            S_RESP: begin
                if (owner_ld_q) begin
                    bus.ld_rvalid = 1'b1;
                    bus.ld_rdata  = rdata_q;
                    bus.ld_err    = err_q;
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = rdata_q;
                    bus.if_err    = err_q;
                end
            end
            default: begin
            end
        endcase
    end
endmodule
